// File: rtl/xor_checksum_arbiter.sv
// Round-robin arbiter that grants one whole packet at a time to a shared XOR accumulator
// and returns the packet checksum, requester ID and saturating word count.
module xor_checksum_arbiter #(
  parameter int unsigned W     = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ-1:0]   REQ_LAST,
  input  logic [NREQ*W-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_READY,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [W-1:0]      RES_DATA,
  output logic [ID_W-1:0]   RES_ID,
  output logic [CNT_W-1:0]  RES_COUNT,
  output logic              BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   g_q, g_d, ptr_q, ptr_d, ptr_nxt;
  logic [W-1:0]      acc_q, acc_d, acc_x;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]      res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;

  logic [ID_W-1:0]   pick, pick_hi, pick_lo;
  logic              hit_hi, hit_lo, any_valid;
  logic [W-1:0]      data_g;
  logic              valid_g, last_g;

  // Round-robin pick: lowest valid index at or above ptr, else lowest valid index below it
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (REQ_VALID[i]) begin
        if (32'(i) >= 32'(ptr_q)) begin
          if (!hit_hi) begin
            hit_hi  = 1'b1;
            pick_hi = ID_W'(i);
          end
        end else if (!hit_lo) begin
          hit_lo  = 1'b1;
          pick_lo = ID_W'(i);
        end
      end
    end
    any_valid = hit_hi | hit_lo;
    pick      = hit_hi ? pick_hi : pick_lo;
  end

  // Lane mux for the granted requester
  always_comb begin
    data_g  = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (g_q == ID_W'(i)) begin
        data_g  = REQ_DATA[i*W +: W];
        valid_g = REQ_VALID[i];
        last_g  = REQ_LAST[i];
      end
    end
  end

  assign acc_x   = acc_q ^ data_g;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign ptr_nxt = (32'(g_q) == 32'(NREQ - 1)) ? '0 : g_q + ID_W'(1);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_valid)                  state_d = S_ACCUM;
      S_ACCUM:  if (valid_g && last_g)          state_d = S_RESULT;
      S_RESULT: if (res_valid_q && RES_READY)   state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // Datapath next values; REQ_READY is a pure decode of registered state and grant
  always_comb begin
    g_d         = g_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_cnt_d   = res_cnt_q;
    res_valid_d = res_valid_q;
    REQ_READY   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      REQ_READY[i] = (state_q == S_ACCUM) && (g_q == ID_W'(i));
    end
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          g_d   = pick;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_ACCUM: begin
        if (valid_g) begin
          acc_d = acc_x;
          cnt_d = cnt_inc;
          if (last_g) begin
            res_data_d  = acc_x;
            res_cnt_d   = cnt_inc;
            res_id_d    = g_q;
            res_valid_d = 1'b1;
            ptr_d       = ptr_nxt;
          end
        end
      end
      S_RESULT: begin
        if (res_valid_q && RES_READY) res_valid_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      g_q         <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_cnt_q   <= res_cnt_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_ID    = res_id_q;
  assign RES_COUNT = res_cnt_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_xor_checksum_arbiter.sv
// Bench for xor_checksum_arbiter: directed scenarios plus random packets, checked every cycle
// against a packet-level round-robin model; a CNT_W=2 copy shares the stimulus.
module tb_xor_checksum_arbiter;

  localparam int unsigned W    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  typedef struct {
    int unsigned data;
    bit          last;
    int unsigned gap;
  } word_t;

  typedef struct {
    int unsigned data;
    int unsigned id;
    int unsigned cnt;
    int unsigned cnt2;
  } res_t;

  logic              CLK = 1'b0;
  logic              RN  = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [NREQ*W-1:0] req_data  = '0;
  logic              res_ready = 1'b0;

  logic [NREQ-1:0]   req_ready, req_ready2;
  logic              res_valid, res_valid2, busy, busy2;
  logic [W-1:0]      res_data, res_data2;
  logic [ID_W-1:0]   res_id, res_id2;
  logic [7:0]        res_count;
  logic [1:0]        res_count2;

  xor_checksum_arbiter #(.W(W), .NREQ(NREQ), .ID_W(ID_W), .CNT_W(8)) u_dut (
    .CLK(CLK), .RN(RN), .REQ_VALID(req_valid), .REQ_LAST(req_last), .REQ_DATA(req_data),
    .REQ_READY(req_ready), .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data),
    .RES_ID(res_id), .RES_COUNT(res_count), .BUSY(busy)
  );

  xor_checksum_arbiter #(.W(W), .NREQ(NREQ), .ID_W(ID_W), .CNT_W(2)) u_dut_sat (
    .CLK(CLK), .RN(RN), .REQ_VALID(req_valid), .REQ_LAST(req_last), .REQ_DATA(req_data),
    .REQ_READY(req_ready2), .RES_VALID(res_valid2), .RES_READY(res_ready), .RES_DATA(res_data2),
    .RES_ID(res_id2), .RES_COUNT(res_count2), .BUSY(busy2)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  word_t       q[NREQ][$];
  res_t        log_q[$];
  int unsigned d_drv[NREQ];
  logic [NREQ-1:0] rdy_s = '0;
  int unsigned stall_left = 0;
  bit          rand_rdy   = 1'b0;

  // Packet-level model: 0 idle, 1 collecting a packet, 2 holding a result
  int unsigned m_mode, m_g, m_ptr, m_acc, m_cnt;
  int unsigned e_data, e_id, e_cnt;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_g = 0; m_ptr = 0; m_acc = 0; m_cnt = 0;
    e_data = 0; e_id = 0; e_cnt = 0;
  endtask

  task automatic push_word(input int r, input int unsigned data, input bit last, input int unsigned gap);
    word_t w;
    w.data = data; w.last = last; w.gap = gap;
    q[r].push_back(w);
  endtask

  task automatic gen_pkt(input int r, input int len);
    for (int k = 0; k < len; k++)
      push_word(r, $urandom_range(0, 255), k == len - 1,
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
  endtask

  // Apply inputs at the falling edge; idle lanes carry junk data and LAST
  task automatic drive();
    word_t w;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_valid[i] = 1'b0;
      req_last[i]  = 1'($urandom_range(0, 1));
      d_drv[i]     = $urandom_range(0, 255);
      if (q[i].size() > 0) begin
        w = q[i][0];
        if (w.gap > 0) begin
          w.gap--;
          q[i][0] = w;
        end else begin
          req_valid[i] = 1'b1;
          req_last[i]  = w.last;
          d_drv[i]     = w.data;
        end
      end
      req_data[i*W +: W] = 8'(d_drv[i]);
    end
    if (res_valid && stall_left > 0) begin
      res_ready = 1'b0;
      stall_left--;
    end else begin
      res_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    rdy_s = req_ready;
    if (res_valid && res_ready)
      log_q.push_back('{data: res_data, id: res_id, cnt: res_count, cnt2: res_count2});
  endtask

  task automatic model_edge();
    case (m_mode)
      0: if (|req_valid) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          if (req_valid[(m_ptr + k) % NREQ]) begin
            m_g = (m_ptr + k) % NREQ;
            break;
          end
        end
        m_acc = 0; m_cnt = 0; m_mode = 1;
      end
      1: if (req_valid[m_g]) begin
        m_acc = m_acc ^ d_drv[m_g];
        m_cnt++;
        if (req_last[m_g]) begin
          e_data = m_acc; e_id = m_g; e_cnt = m_cnt;
          m_ptr  = (m_g + 1) % NREQ;
          m_mode = 2;
        end
      end
      default: if (res_ready) m_mode = 0;
    endcase
    for (int i = 0; i < int'(NREQ); i++)
      if (req_valid[i] && rdy_s[i]) void'(q[i].pop_front());
  endtask

  task automatic check_outputs();
    int unsigned exp_rdy;
    exp_rdy = (m_mode == 1) ? (1 << m_g) : 0;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("ready_onehot", ($countones(req_ready) <= 1), 1);
    check_eq("res_valid", res_valid, m_mode == 2);
    check_eq("busy", busy, m_mode != 0);
    check_eq("res_data", res_data, e_data);
    check_eq("res_id", res_id, e_id);
    check_eq("res_count", res_count, sat(e_cnt, 255));
    check_eq("sat_req_ready", req_ready2, exp_rdy);
    check_eq("sat_res_valid", res_valid2, m_mode == 2);
    check_eq("sat_busy", busy2, m_mode != 0);
    check_eq("sat_res_data", res_data2, e_data);
    check_eq("sat_res_id", res_id2, e_id);
    check_eq("sat_res_count", res_count2, sat(e_cnt, 3));
  endtask

  task automatic step();
    drive();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_mode != 0) && n < 4000) begin
      step();
      n++;
    end
    check_eq({tag, "_drain_bound"}, n < 4000, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, res_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, req_ready, 0);
    check_eq({tag, "_data"}, res_data, 0);
    check_eq({tag, "_id"}, res_id, 0);
    check_eq({tag, "_count"}, res_count, 0);
  endtask

  // Asynchronous reset pulse starting between clock edges; pending packets are dropped
  task automatic pulse_reset();
    #2 RN = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    for (int i = 0; i < int'(NREQ); i++) q[i].delete();
    req_valid = '0;
    req_last  = '0;
    @(posedge CLK);
    @(negedge CLK);
    RN = 1'b1;
  endtask

  task automatic check_log(input string tag, input int idx, input int unsigned data,
                           input int unsigned id, input int unsigned cnt, input int unsigned cnt2);
    res_t r;
    if (idx >= log_q.size()) begin
      check_eq({tag, "_present"}, 0, 1);
    end else begin
      r = log_q[idx];
      check_eq({tag, "_data"}, r.data, data);
      check_eq({tag, "_id"}, r.id, id);
      check_eq({tag, "_count"}, r.cnt, cnt);
      check_eq({tag, "_satcount"}, r.cnt2, cnt2);
    end
  endtask

  initial begin
    int n;
    model_reset();
    #1 check_reset_outputs("por");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RN = 1'b1;

    // Idle with no requests
    repeat (10) step();

    // Three-word packet from requester 1 with latency measurement
    log_q.delete();
    push_word(1, 'h3C, 0, 0); push_word(1, 'hA5, 0, 0); push_word(1, 'h0F, 1, 0);
    n = 0;
    do begin step(); n++; end while (!res_valid && n < 50);
    check_eq("latency_3word", n, 4);
    drain("t_basic");
    check_eq("t_basic_results", log_q.size(), 1);
    check_log("t_basic", 0, 'h96, 1, 3, 3);

    // Two requesters contending from ptr=0
    pulse_reset();
    log_q.delete();
    push_word(0, 'h11, 1, 0); push_word(0, 'h11, 1, 0);
    push_word(2, 'h22, 1, 0); push_word(2, 'h22, 1, 0);
    drain("t_rr");
    check_eq("t_rr_results", log_q.size(), 4);
    check_log("t_rr0", 0, 'h11, 0, 1, 1);
    check_log("t_rr1", 1, 'h22, 2, 1, 1);
    check_log("t_rr2", 2, 'h11, 0, 1, 1);
    check_log("t_rr3", 3, 'h22, 2, 1, 1);

    // Gap inside a packet and a stalled result, with requester 0 waiting behind it
    log_q.delete();
    stall_left = 5;
    push_word(3, 'h01, 0, 0); push_word(3, 'hFF, 1, 3);
    push_word(0, 'h5A, 1, 0);
    drain("t_stall");
    check_eq("t_stall_results", log_q.size(), 2);
    check_eq("t_stall_consumed", stall_left, 0);
    check_log("t_stall0", 0, 'hFE, 3, 2, 2);
    check_log("t_stall1", 1, 'h5A, 0, 1, 1);

    // Counter saturation in the CNT_W=2 copy
    log_q.delete();
    for (int k = 0; k < 5; k++) push_word(1, 'h01, k == 4, 0);
    drain("t_sat");
    check_log("t_sat", 0, 'h01, 1, 5, 3);

    // Reset in the middle of a packet
    log_q.delete();
    push_word(1, 'h12, 0, 0); push_word(1, 'h34, 0, 0);
    push_word(1, 'h56, 0, 0); push_word(1, 'h78, 1, 0);
    n = 0;
    while (!(m_mode == 1 && m_cnt == 2) && n < 20) begin step(); n++; end
    check_eq("t_midrst_reached", n < 20, 1);
    pulse_reset();
    push_word(0, 'h55, 1, 0);
    drain("t_midrst");
    check_eq("t_midrst_results", log_q.size(), 1);
    check_log("t_midrst", 0, 'h55, 0, 1, 1);

    // Random packets, gaps and result back-pressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 250; p++) begin
      gen_pkt($urandom_range(0, NREQ - 1),
              ($urandom_range(0, 9) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 5));
      repeat ($urandom_range(1, 8)) step();
    end
    drain("t_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
